sram_cache_controller: RTL
==========================

Name: sram_cache_controller

Overview:
- Two-way set-associative read cache between the MEM stage and the SRAM controller.
- Acts as the initiator on the SRAM controller's request/ready interface, and as the responder to the pipeline on the same wrEn/rdEn/ready style interface.
- Read hits complete in the request cycle. Read misses fetch a 64-bit block. Writes are write-through and no-write-allocate.

Parameters:
- BASE_ADDR, 1024, start of data memory; subtracted from addressIn before index/tag extraction.
- SETS, 64, number of sets; index width is log2(SETS) = 6.
- TAG_W, 10, tag width; tag = memAddr[18:9].

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- rdEnIn  in  1  pipeline read request, held until readyOut=1.
- wrEnIn  in  1  pipeline write request, held until readyOut=1.
- addressIn  in  32  byte address; memAddr = addressIn - BASE_ADDR; word select memAddr[2], index memAddr[8:3], tag memAddr[18:9].
- writeDataIn  in  32  store data.
- readDataOut  out  32  load data, valid while readyOut=1 with rdEnIn=1.
- readyOut  out  1  request completes at this edge; pipeline freezes while 0.
- sramRdEnOut  out  1  read request to the SRAM controller.
- sramWrEnOut  out  1  write request to the SRAM controller.
- sramAddressOut  out  32  = addressIn (unmodified; the controller subtracts the base itself).
- sramWriteDataOut  out  32  = writeDataIn.
- sramReadDataIn  in  64  block from the controller: [31:0] is word 0, [63:32] is word 1.
- sramReadyIn  in  1  controller done or idle.

Behaviour:
- Storage per set:
  - 2 ways, each with valid, TAG_W-bit tag and 64-bit data.
  - One LRU bit per set, naming the least-recently-used way.
- Reset (rst=0, async):
  - All valid and LRU bits cleared; state IDLE.
  - sramRdEnOut and sramWrEnOut = 0; readyOut = 1; readDataOut = 0.
  - Data and tag arrays are not reset.
- Hit: way w is valid and its tag matches. If both ways match, way 0 wins; this must never occur in operation.
- State IDLE:
  - No request: readyOut = 1, SRAM requests 0.
  - wrEnIn=1 (wins over rdEnIn): readyOut = 0, go to WRITE.
  - rdEnIn=1 and hit: readyOut = 1 combinationally. readDataOut = word memAddr[2] of the hit way. At the edge, LRU[index] = ~w. Stay in IDLE (zero wait cycles).
  - rdEnIn=1 and miss: readyOut = 0, go to READ_MISS.
- State READ_MISS:
  - sramRdEnOut = 1.
  - While sramReadyIn = 0: readyOut = 0, hold state.
  - When sramReadyIn = 1: readyOut = 1 and readDataOut = the selected 32-bit word of sramReadDataIn (forwarded in the same cycle).
  - At that edge: fill the victim way (invalid way 0 first, then invalid way 1, else way LRU[index]) with data, tag and valid=1. Set LRU[index] to the other way. Return to IDLE.
- State WRITE:
  - sramWrEnOut = 1.
  - When sramReadyIn = 1: readyOut = 1. At that edge, on a cache hit, overwrite word memAddr[2] of the hit way and set LRU[index] = ~w; on a miss, leave the cache unchanged (no allocate). Return to IDLE.
- SRAM handshake: requests are registered/state-driven and deasserted on the same edge at which sramReadyIn=1 is sampled. The controller must never see a request in the cycle after completion.
- Request drops mid-transaction (protocol violation): the SRAM transaction still runs to completion; the cache is filled or updated as normal.
- Reset mid-transaction: state returns to IDLE immediately and all valid bits are lost. The SRAM controller is reset on the same net.

Test Plan:
- Cold read 1024, sramReadDataIn = 0x11112222_33334444 after 6 wait cycles -> sramRdEnOut held for 6 cycles; readDataOut = 0x33334444 with readyOut=1; set 0 way 0 valid with tag 0.
- Read 1028 next -> hit in the same cycle: readyOut=1, readDataOut = 0x11112222, sramRdEnOut stays 0.
- Read 1536 (tag 1) then 2048 (tag 2), all set 0 -> tag 1 fills way 1; tag 2 evicts the LRU way 0 (way 0 was used last by the 1028 hit, then way 1 was used). Re-reading 1024 misses.
- Write 1028 with 0xDEADBEEF on a hit line -> sramWrEnOut = 1 until sramReadyIn; a later read of 1028 hits and returns 0xDEADBEEF. Write to an uncached 4096 -> no allocation; a following read misses.
- rdEnIn and wrEnIn both 1 -> treated as a write, sramRdEnOut = 0.
- rst pulled low during READ_MISS -> sramRdEnOut = 0 and readyOut = 1 asynchronously; after release, a read of 1024 misses.

Source files
------------

// File: rtl/sram_cache_controller.sv
// Two-way set-associative, write-through / no-write-allocate read cache that
// sits between the MEM stage and the SRAM controller. Read hits finish in-cycle.
module sram_cache_controller #(
  parameter logic [31:0] BASE_ADDR = 32'd1024,
  parameter int          SETS      = 64,
  parameter int          TAG_W     = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdEnIn,
  input  logic        wrEnIn,
  input  logic [31:0] addressIn,
  input  logic [31:0] writeDataIn,
  output logic [31:0] readDataOut,
  output logic        readyOut,
  output logic        sramRdEnOut,
  output logic        sramWrEnOut,
  output logic [31:0] sramAddressOut,
  output logic [31:0] sramWriteDataOut,
  input  logic [63:0] sramReadDataIn,
  input  logic        sramReadyIn
);

  localparam int IDX_W = $clog2(SETS);
  localparam int MA_W  = 3 + IDX_W + TAG_W;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] READ_MISS = 2'd1;
  localparam logic [1:0] WRITE     = 2'd2;

  logic [1:0]       state_reg;
  logic [TAG_W-1:0] lat_tag_reg;
  logic [IDX_W-1:0] lat_index_reg;
  logic             lat_word_reg;
  logic [31:0]      lat_wdata_reg;
  logic [1:0][SETS-1:0] valid_reg;
  logic [SETS-1:0]  lru_reg;

  // Word-granular memAddr; the byte-offset borrow keeps the subtraction exact.
  logic             borrow;
  logic [MA_W-3:0]  mem_word;
  logic             cur_word;
  logic [IDX_W-1:0] cur_index;
  logic [TAG_W-1:0] cur_tag;

  assign borrow    = addressIn[1:0] < BASE_ADDR[1:0];
  assign mem_word  = addressIn[MA_W-1:2] - BASE_ADDR[MA_W-1:2]
                   - {{(MA_W-3){1'b0}}, borrow};
  assign cur_word  = mem_word[0];
  assign cur_index = mem_word[1 +: IDX_W];
  assign cur_tag   = mem_word[1+IDX_W +: TAG_W];

  // Lookups use the live address in IDLE and the captured one mid-transaction.
  logic             lk_word;
  logic [IDX_W-1:0] lk_index;
  logic [TAG_W-1:0] lk_tag;

  assign lk_word  = (state_reg == IDLE) ? cur_word  : lat_word_reg;
  assign lk_index = (state_reg == IDLE) ? cur_index : lat_index_reg;
  assign lk_tag   = (state_reg == IDLE) ? cur_tag   : lat_tag_reg;

  logic [1:0][63:0]      way_data;
  logic [1:0][TAG_W-1:0] way_tag;
  logic [1:0]            way_hit;
  logic                  hit;
  logic                  hit_way;
  logic                  victim;
  logic                  fill_en;
  logic                  update_en;
  logic [63:0]           hit_line;
  logic [31:0]           hit_word;
  logic [31:0]           sram_word;

  assign hit       = |way_hit;
  assign hit_way   = ~way_hit[0];
  assign hit_line  = way_hit[0] ? way_data[0] : way_data[1];
  assign hit_word  = lk_word ? hit_line[63:32] : hit_line[31:0];
  assign sram_word = lat_word_reg ? sramReadDataIn[63:32] : sramReadDataIn[31:0];
  assign victim    = ~valid_reg[0][lat_index_reg] ? 1'b0 :
                     ~valid_reg[1][lat_index_reg] ? 1'b1 : lru_reg[lat_index_reg];
  assign fill_en   = (state_reg == READ_MISS) && sramReadyIn;
  assign update_en = (state_reg == WRITE) && sramReadyIn && hit;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : gen_way
      logic [TAG_W-1:0] tag_mem  [SETS];
      logic [63:0]      data_mem [SETS];

      assign way_tag[gi]  = tag_mem[lk_index];
      assign way_data[gi] = data_mem[lk_index];
      assign way_hit[gi]  = valid_reg[gi][lk_index] && (way_tag[gi] == lk_tag);

      always_ff @(posedge clk) begin
        if (fill_en && (victim == 1'(gi))) begin
          tag_mem[lat_index_reg]  <= lat_tag_reg;
          data_mem[lat_index_reg] <= sramReadDataIn;
        end else if (update_en && (hit_way == 1'(gi))) begin
          if (lat_word_reg) data_mem[lat_index_reg][63:32] <= lat_wdata_reg;
          else              data_mem[lat_index_reg][31:0]  <= lat_wdata_reg;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      valid_reg     <= '0;
      lru_reg       <= '0;
      lat_tag_reg   <= '0;
      lat_index_reg <= '0;
      lat_word_reg  <= 1'b0;
      lat_wdata_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (wrEnIn || (rdEnIn && !hit)) begin
            state_reg     <= wrEnIn ? WRITE : READ_MISS;
            lat_tag_reg   <= cur_tag;
            lat_index_reg <= cur_index;
            lat_word_reg  <= cur_word;
            lat_wdata_reg <= writeDataIn;
          end else if (rdEnIn) begin
            lru_reg[cur_index] <= ~hit_way;
          end
        end
        READ_MISS: begin
          if (sramReadyIn) begin
            valid_reg[victim][lat_index_reg] <= 1'b1;
            lru_reg[lat_index_reg]           <= ~victim;
            state_reg                        <= IDLE;
          end
        end
        WRITE: begin
          if (sramReadyIn) begin
            if (hit) lru_reg[lat_index_reg] <= ~hit_way;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Reset forces the idle pipeline view even if a request is still held.
  always_comb begin
    readyOut    = 1'b1;
    readDataOut = '0;
    if (rst) begin
      case (state_reg)
        IDLE: begin
          if (wrEnIn) begin
            readyOut = 1'b0;
          end else if (rdEnIn) begin
            readyOut = hit;
            if (hit) readDataOut = hit_word;
          end
        end
        READ_MISS: begin
          readyOut = sramReadyIn;
          if (sramReadyIn) readDataOut = sram_word;
        end
        WRITE:   readyOut = sramReadyIn;
        default: readyOut = 1'b1;
      endcase
    end
  end

  assign sramRdEnOut      = (state_reg == READ_MISS);
  assign sramWrEnOut      = (state_reg == WRITE);
  assign sramAddressOut   = addressIn;
  assign sramWriteDataOut = writeDataIn;

endmodule
